// File: rtl/fu_issue_ctrl.sv
// Issue-stall and CDB writeback scheduler between the reservation station and the FUs.
// Load FSM: IDLE=no load | WAIT=awaiting mem_done | HOLD=result ready, needs a CDB slot | DRAIN=squashed load awaiting mem_done
module fu_issue_ctrl #(
  parameter int SS_SIZE      = 2,
  parameter int NUM_FU_TOTAL = 5,
  parameter int FU_ALU0_IDX  = 0,
  parameter int FU_ALU1_IDX  = 1,
  parameter int FU_LD_IDX    = 2,
  parameter int FU_MULT_IDX  = 3,
  parameter int FU_BR_IDX    = 4,
  parameter int MULT_LAT     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_FU_TOTAL-1:0] issue_valid,
  input  logic                    mem_done,
  input  logic                    branch_not_taken,
  output logic [NUM_FU_TOTAL-1:0] issue_stall,
  output logic [NUM_FU_TOTAL-1:0] cdb_fu_valid,
  output logic [1:0]              ld_state
);

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_WAIT  = 2'd1,
    LD_HOLD  = 2'd2,
    LD_DRAIN = 2'd3
  } ld_state_e;

  localparam logic [NUM_FU_TOTAL-1:0] ONE_BIT   = NUM_FU_TOTAL'(1);
  localparam logic [NUM_FU_TOTAL-1:0] ALU0_BIT  = ONE_BIT << FU_ALU0_IDX;
  localparam logic [NUM_FU_TOTAL-1:0] ALU1_BIT  = ONE_BIT << FU_ALU1_IDX;
  localparam logic [NUM_FU_TOTAL-1:0] LD_BIT    = ONE_BIT << FU_LD_IDX;
  localparam logic [NUM_FU_TOTAL-1:0] MULT_BIT  = ONE_BIT << FU_MULT_IDX;
  localparam logic [NUM_FU_TOTAL-1:0] BR_BIT    = ONE_BIT << FU_BR_IDX;
  localparam logic [NUM_FU_TOTAL-1:0] LAT1_MASK = ALU0_BIT | ALU1_BIT | BR_BIT;

  logic [NUM_FU_TOTAL-1:0] comp_mask [0:MULT_LAT];
  logic [NUM_FU_TOTAL-1:0] comp_next [0:MULT_LAT];
  logic [NUM_FU_TOTAL-1:0] accepted;
  logic [1:0]              rr_ptr;
  ld_state_e               ld_q;
  logic [2:0]              lat1_stall;
  logic                    ld_wb;
  int                      free_slots;

  function automatic int popcnt(input logic [NUM_FU_TOTAL-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_FU_TOTAL; i++) cnt += int'(v[i]);
    return cnt;
  endfunction

  // Stalls look only at registered state so the RS never sees a loop through issue_valid.
  always_comb begin
    free_slots = SS_SIZE - popcnt(comp_mask[1]) - ((ld_q == LD_HOLD) ? 1 : 0);
    if (free_slots < 0) free_slots = 0;
    lat1_stall = '0;
    for (int g = 0; g < 3; g++) begin
      if (((g + 3 - int'(rr_ptr)) % 3) >= free_slots) lat1_stall[g] = 1'b1;
    end
    issue_stall              = '0;
    issue_stall[FU_ALU0_IDX] = lat1_stall[0];
    issue_stall[FU_ALU1_IDX] = lat1_stall[1];
    issue_stall[FU_BR_IDX]   = lat1_stall[2];
    issue_stall[FU_MULT_IDX] = (popcnt(comp_mask[MULT_LAT]) >= SS_SIZE);
    issue_stall[FU_LD_IDX]   = (ld_q != LD_IDLE);
  end

  always_comb begin
    ld_wb        = (ld_q == LD_HOLD) && (popcnt(comp_mask[0]) < SS_SIZE);
    cdb_fu_valid = comp_mask[0] | (ld_wb ? LD_BIT : '0);
  end

  assign accepted = issue_valid & ~issue_stall;
  assign ld_state = ld_q;

  always_comb begin
    for (int k = 0; k < MULT_LAT; k++) comp_next[k] = comp_mask[k+1];
    comp_next[MULT_LAT]   = '0;
    comp_next[0]          = comp_next[0] | (accepted & LAT1_MASK);
    comp_next[MULT_LAT-1] = comp_next[MULT_LAT-1] | (accepted & MULT_BIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k <= MULT_LAT; k++) comp_mask[k] <= '0;
      rr_ptr <= 2'd0;
      ld_q   <= LD_IDLE;
    end else if (branch_not_taken) begin
      // Squash drops every reservation; rr_ptr keeps its position.
      for (int k = 0; k <= MULT_LAT; k++) comp_mask[k] <= '0;
      case (ld_q)
        LD_WAIT: ld_q <= LD_DRAIN;
        LD_HOLD: ld_q <= LD_IDLE;
        default: ld_q <= ld_q;
      endcase
    end else begin
      for (int k = 0; k <= MULT_LAT; k++) comp_mask[k] <= comp_next[k];
      if (|lat1_stall) rr_ptr <= (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
      case (ld_q)
        LD_IDLE:  if (accepted[FU_LD_IDX]) ld_q <= LD_WAIT;
        LD_WAIT:  if (mem_done)            ld_q <= LD_HOLD;
        LD_HOLD:  if (ld_wb)               ld_q <= LD_IDLE;
        LD_DRAIN: if (mem_done)            ld_q <= LD_IDLE;
        default:                           ld_q <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Bench for fu_issue_ctrl: absolute-time completion model checked every cycle, plus literal pins.
module tb_fu_issue_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] issue_valid = '0;
  logic       mem_done = 1'b0;
  logic       branch_not_taken = 1'b0;
  logic [4:0] issue_stall;
  logic [4:0] cdb_fu_valid;
  logic [1:0] ld_state;

  fu_issue_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .mem_done         (mem_done),
    .branch_not_taken (branch_not_taken),
    .issue_stall      (issue_stall),
    .cdb_fu_valid     (cdb_fu_valid),
    .ld_state         (ld_state)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pc(input logic [4:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 5; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int grp_idx(input int p);
    return (p == 2) ? 4 : p;
  endfunction

  // Model: sched[t % 16] holds the FUs due to write the CDB in absolute cycle t.
  // Load states: 0 idle, 1 waiting for memory, 2 holding result, 3 draining squashed load.
  logic [4:0] sched [16];
  int m_cyc, m_rr, m_ld;
  int done_cnt [5];

  always @(negedge clock) begin
    logic [4:0] now_m, nxt_m, far_m, e_stall, e_cdb, acc;
    int free_n, rank;
    bit hold, wb;
    if (reset) begin
      for (int i = 0; i < 16; i++) sched[i] = '0;
      m_cyc = 0;
      m_rr  = 0;
      m_ld  = 0;
    end else begin
      now_m = sched[m_cyc % 16];
      nxt_m = sched[(m_cyc + 1) % 16];
      far_m = sched[(m_cyc + 4) % 16];
      hold  = (m_ld == 2);
      free_n = 2 - pc(nxt_m) - (hold ? 1 : 0);
      if (free_n < 0) free_n = 0;
      e_stall = '0;
      for (int p = 0; p < 3; p++) begin
        rank = (p - m_rr + 3) % 3;
        if (rank >= free_n) e_stall[grp_idx(p)] = 1'b1;
      end
      if (pc(far_m) >= 2) e_stall[3] = 1'b1;
      if (m_ld != 0) e_stall[2] = 1'b1;
      wb    = hold && (pc(now_m) < 2);
      e_cdb = now_m | (wb ? 5'b00100 : 5'b00000);

      chk("issue_stall", issue_stall, e_stall);
      chk("cdb_fu_valid", cdb_fu_valid, e_cdb);
      chk("ld_state", ld_state, m_ld);
      chk("cdb_popcount_le_2", (pc(cdb_fu_valid) <= 2), 1);
      for (int i = 0; i < 5; i++) if (cdb_fu_valid[i]) done_cnt[i]++;

      sched[m_cyc % 16] = '0;
      if (branch_not_taken) begin
        for (int i = 0; i < 16; i++) sched[i] = '0;
        if (m_ld == 1) m_ld = 3;
        else if (m_ld == 2) m_ld = 0;
      end else begin
        acc = issue_valid & ~e_stall;
        sched[(m_cyc + 1) % 16] = sched[(m_cyc + 1) % 16] | (acc & 5'b10011);
        if (acc[3]) sched[(m_cyc + 4) % 16] = sched[(m_cyc + 4) % 16] | 5'b01000;
        if ((e_stall & 5'b10011) != 5'b00000) m_rr = (m_rr + 1) % 3;
        case (m_ld)
          0: if (acc[2]) m_ld = 1;
          1: if (mem_done) m_ld = 2;
          2: if (wb) m_ld = 0;
          3: if (mem_done) m_ld = 0;
          default: m_ld = 0;
        endcase
      end
      m_cyc++;
    end
  end

  task automatic drive(input logic [4:0] v, input logic md, input logic sq);
    issue_valid      = v;
    mem_done         = md;
    branch_not_taken = sq;
    @(negedge clock);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 expected end earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap [5];
    for (int i = 0; i < 5; i++) done_cnt[i] = 0;
    reset = 1'b1;
    adv();
    adv();
    reset = 1'b0;

    // c0..c2: reset state, then rr_ptr rotation
    drive(5'b00000, 0, 0);
    chk("rst_stall", issue_stall, 5'b10000);
    chk("rst_cdb", cdb_fu_valid, 5'b00000);
    chk("rst_ld_state", ld_state, 2'd0);
    adv();
    drive(5'b00000, 0, 0); chk("c1_stall", issue_stall, 5'b00001); adv();
    drive(5'b00000, 0, 0); chk("c2_stall", issue_stall, 5'b00010); adv();

    // c3 MULT, c6 ALU0+ALU1 -> only rank-0 ALU0 accepted, c7 MULT+ALU0
    drive(5'b01000, 0, 0); chk("c3_stall", issue_stall, 5'b10000); adv();
    drive(5'b00000, 0, 0); adv();
    drive(5'b00000, 0, 0); adv();
    drive(5'b00011, 0, 0); chk("c6_stall_one_slot", issue_stall, 5'b10010); adv();
    drive(5'b00000, 0, 0); chk("c7_cdb_mult_alu0", cdb_fu_valid, 5'b01001); adv();
    drive(5'b00000, 0, 0); adv();

    // c9 LD with ALUs busy; mem_done at c14, HOLD and writeback at c15
    drive(5'b00111, 0, 0); chk("c9_stall", issue_stall, 5'b10000); adv();
    drive(5'b00011, 0, 0); chk("c10_stall_ld_wait", issue_stall, 5'b00101); adv();
    drive(5'b00011, 0, 0); adv();
    drive(5'b00011, 0, 0); adv();
    drive(5'b00011, 0, 0); adv();
    drive(5'b00011, 1, 0); chk("c14_ld_wait", ld_state, 2'd1); adv();
    drive(5'b00011, 0, 0);
    chk("c15_ld_hold", ld_state, 2'd2);
    chk("c15_cdb_ld_wb", cdb_fu_valid, 5'b00101);
    chk("c15_stall_hold", issue_stall, 5'b10110);
    adv();
    drive(5'b00000, 0, 0);
    chk("c16_ld_idle", ld_state, 2'd0);
    chk("c16_stall", issue_stall, 5'b00001);
    adv();

    // c17 LD, c19 squash, c23 mem_done -> DRAIN c20..c23, IDLE c24
    drive(5'b00100, 0, 0); chk("c17_stall", issue_stall, 5'b00010); adv();
    drive(5'b00010, 0, 0); adv();
    drive(5'b00011, 0, 1); chk("c19_cdb", cdb_fu_valid, 5'b00010); adv();
    drive(5'b00000, 0, 0);
    chk("c20_ld_drain", ld_state, 2'd3);
    chk("c20_cdb_squashed", cdb_fu_valid, 5'b00000);
    chk("c20_stall_rr_kept", issue_stall, 5'b00101);
    adv();
    drive(5'b00000, 0, 0); adv();
    drive(5'b00000, 0, 0); adv();
    drive(5'b00000, 1, 0); chk("c23_ld_drain", ld_state, 2'd3); adv();
    drive(5'b00000, 0, 0);
    chk("c24_ld_idle", ld_state, 2'd0);
    chk("c24_stall", issue_stall, 5'b00010);
    adv();

    // c25 MULT, c26 squash -> no CDB activity through c31
    drive(5'b01000, 0, 0); chk("c25_cdb", cdb_fu_valid, 5'b00000); adv();
    drive(5'b00000, 0, 1); chk("c26_cdb", cdb_fu_valid, 5'b00000); adv();
    for (int c = 27; c <= 31; c++) begin
      drive(5'b00000, 0, 0);
      chk("mult_squash_cdb_zero", cdb_fu_valid, 5'b00000);
      adv();
    end

    // c32 LD, c33 mem_done with ALU1+BR, c34 HOLD blocked by full CDB and squashed
    drive(5'b00100, 0, 0); adv();
    drive(5'b10010, 1, 0); adv();
    drive(5'b00000, 0, 1);
    chk("c34_ld_hold", ld_state, 2'd2);
    chk("c34_cdb_full", cdb_fu_valid, 5'b10010);
    chk("c34_stall", issue_stall, 5'b00111);
    adv();
    drive(5'b00000, 0, 0);
    chk("c35_ld_idle", ld_state, 2'd0);
    chk("c35_cdb", cdb_fu_valid, 5'b00000);
    chk("c35_stall", issue_stall, 5'b00010);
    adv();

    // Saturating issue for 30 cycles
    for (int i = 0; i < 5; i++) snap[i] = done_cnt[i];
    for (int i = 0; i < 30; i++) begin
      drive(5'b11111, ((i % 10) == 4), 0);
      adv();
    end
    for (int i = 0; i < 8; i++) begin
      drive(5'b00000, 1, 0);
      adv();
    end
    chk("alu0_completions_ge_6", ((done_cnt[0] - snap[0]) >= 6), 1);
    chk("alu1_completions_ge_6", ((done_cnt[1] - snap[1]) >= 6), 1);
    chk("br_completions_ge_6", ((done_cnt[4] - snap[4]) >= 6), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
